seq_approx_div_ctrl: RTL
========================

// Module: seq_approx_div_ctrl
// PURPOSE
//  Iterative 16/8 restoring divider controller: one 9-bit subtract/restore row, reused over 8 cycles.
//  Per iteration, a mask selects how many row LSB cells use the approximate cell (AD1 depth schedule).
//  The per-operation approx_mode input selects a fully exact schedule or the approximate one.
//  Time-multiplexed replacement for the 8-row combinational divider array.
// PARAMETERS
//  APPROX_START  5  first iteration index (0..7) that uses approximate LSB cells
//  APPROX_MAX    3  cap on the number of approximate LSB cells in any iteration
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   request; sampled only in IDLE or DONE
//  dividend   in   16  captured on accepted start
//  divisor    in   8   captured on accepted start
//  approx_mode in  1   captured on accepted start; 0 = all cells exact
//  busy       out  1   high while in RUN
//  done       out  1   one-cycle pulse; results valid
//  quotient   out  8   held until the next accepted start
//  remainder  out  8   held until the next accepted start
//  div_zero   out  1   only with DIV_ZERO_DETECT_EN; held with the results
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, quotient, remainder, div_zero, k and R are all 0.
//  FSM: IDLE -start-> RUN; RUN -k==7-> DONE; DONE -start-> RUN, else IDLE.
//   - start in RUN is ignored.
//   - start in DONE is accepted, so back-to-back operations add no bubble.
//  On accept (edge E0): R[7:0]<=dividend[15:8], D<=dividend[7:0], Y<=divisor, M<=approx_mode, k<=0.
//  Iteration k runs at edge E(k+1).
//   - Row input x9 = {R, D[7-k]}; bin tied to 0.
//   - Row output: qs and rout[7:0].
//   - Updates: quotient[7-k]<=qs, R<=rout.
//  Row cell i (i=0..7) inputs: a=x9[i], b=Y[i], bin = borrow from cell i-1.
//   - Exact cell: bout=~a&bin|~a&b|b&bin; r = qs ? a^b^bin : a.
//   - Approx cell: bout=b|~a&bin; r = qs ? a : (a^b|bin).
//   - Row: qs = ~bout7 | x9[8].
//  Approx LSB count n(k):
//   - M=0: n=0.
//   - M=1 and k>=APPROX_START: n = min(k-APPROX_START+1, APPROX_MAX).
//   - Otherwise n=0.
//   - Cells i<n are approximate. Defaults give 0,0,0,0,0,1,2,3.
//  Latency: done=1 during the cycle after E8, i.e. 8 clocks after accept. remainder<=R at E8.
//  No overflow check: dividend[15:8] >= divisor yields the raw row result, unflagged.
//  Reset mid-operation: immediate IDLE with all outputs 0; the operation is lost.
// CONFIGURATION
//  DIV_ZERO_DETECT_EN defined:
//   - Accept with divisor==0 goes directly to DONE at E0.
//   - done in the next cycle; quotient=8'hFF, remainder=8'h00, div_zero=1.
//   - div_zero is cleared on the next accept.
//  DIV_ZERO_DETECT_EN undefined:
//   - No div_zero port.
//   - divisor==0 runs the normal 8 iterations through the row.
// STRUCTURE
//  Package approx_div_pkg holds:
//   - state enum {IDLE,RUN,DONE};
//   - localparam N_ITER=8;
//   - function approx_mask(k, mode) returning an 8-bit LSB mask.
//  Sub-module div_row (combinational): x9, y, approx mask -> qs, rout[7:0]; mask selects cell type per bit.
//  Controller holds the FSM, k counter, R/D/Y/M registers and the result registers.
// TESTING
//  - Exact: dividend=16'h1234, divisor=8'h56, mode=0 -> done 8 clocks later, quotient=8'h36, remainder=8'h10.
//  - Approx: dividend=16'h0000, divisor=8'h05, mode=1 -> quotient=8'h00, remainder=8'h03.
//    Same operands with mode=0 -> quotient=8'h00, remainder=8'h00.
//  - Back-to-back: start held high through DONE.
//    -> second op accepted at the done cycle; done pulses exactly every 9th clock; busy low only in DONE cycles.
//  - start pulsed while busy (k=3) -> ignored; the first result is unchanged and only one done pulse occurs.
//  - rst asserted at k=4 -> busy, done, quotient and remainder go to 0 asynchronously.
//    A new op after reset completes correctly.
//  - divisor=8'h00:
//    - with DIV_ZERO_DETECT_EN: done 1 clock after accept; quotient=8'hFF, remainder=8'h00, div_zero=1.
//    - without it: 8-clock run; results match the bit-accurate cell model.

Source files
------------

// File: rtl/approx_div_pkg.sv
// rtl/approx_div_pkg.sv - shared types, constants and approximate-cell mask helper for seq_approx_div_ctrl
package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_ITER           = 8;
  localparam int APPROX_START_DEF = 5;
  localparam int APPROX_MAX_DEF   = 3;

  // Mask of row LSB cells that use the approximate cell in iteration k.
  // n = min(k - start + 1, amax) once k reaches start in approximate mode, else 0.
  function automatic logic [7:0] approx_mask(
    input logic [2:0] k,
    input logic       mode,
    input int         start = APPROX_START_DEF,
    input int         amax  = APPROX_MAX_DEF
  );
    int         n;
    logic [7:0] m;
    n = 0;
    if (mode && (int'(k) >= start)) begin
      n = int'(k) - start + 1;
      if (n > amax) n = amax;
    end
    m = '0;
    for (int i = 0; i < N_ITER; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_approx_div_ctrl_row.sv
// rtl/seq_approx_div_ctrl_row.sv - one 9-bit subtract/restore divider row with per-bit exact/approximate cells
module div_row (
  input  logic [8:0] x9,
  input  logic [7:0] y,
  input  logic [7:0] mask,
  output logic       qs,
  output logic [7:0] rout
);

  // Ripple the borrow through the 8 cells, then pick subtract or restore per cell
  always_comb begin : row_eval
    logic [8:0] v_bin;
    logic       v_a;
    logic       v_b;
    logic       v_c;
    v_bin = '0;
    rout  = '0;
    for (int i = 0; i < 8; i++) begin
      v_a = x9[i];
      v_b = y[i];
      v_c = v_bin[i];
      if (mask[i]) begin
        v_bin[i+1] = v_b | (~v_a & v_c);
      end else begin
        v_bin[i+1] = (~v_a & v_c) | (~v_a & v_b) | (v_b & v_c);
      end
    end
    // A set ninth bit means the partial remainder certainly exceeds the divisor.
    qs = ~v_bin[8] | x9[8];
    for (int i = 0; i < 8; i++) begin
      v_a = x9[i];
      v_b = y[i];
      v_c = v_bin[i];
      if (mask[i]) begin
        rout[i] = qs ? v_a : ((v_a ^ v_b) | v_c);
      end else begin
        rout[i] = qs ? (v_a ^ v_b ^ v_c) : v_a;
      end
    end
  end

endmodule

// File: rtl/seq_approx_div_ctrl.sv
// rtl/seq_approx_div_ctrl.sv - iterative 16/8 approximate restoring divider controller; optional DIV_ZERO_DETECT_EN
module seq_approx_div_ctrl
  import approx_div_pkg::*;
#(
  parameter int APPROX_START = 5,
  parameter int APPROX_MAX   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  input  logic        approx_mode,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient,
`ifdef DIV_ZERO_DETECT_EN
  output logic        div_zero,
`endif
  output logic [7:0]  remainder
);

  localparam logic [2:0] K_LAST = 3'(N_ITER - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_k;
  logic [7:0] r_r;
  logic [7:0] r_d;
  logic [7:0] r_y;
  logic       r_m;
  logic [7:0] r_q;
  logic [7:0] r_quot;
  logic [7:0] r_rem;
  logic       w_accept;
  logic       w_dz_accept;
  logic [8:0] w_x9;
  logic [7:0] w_mask;
  logic [7:0] w_rout;
  logic       w_qs;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

`ifdef DIV_ZERO_DETECT_EN
  logic r_dz;
  assign w_dz_accept = w_accept && (divisor == 8'h00);
  assign div_zero    = r_dz;
`else
  assign w_dz_accept = 1'b0;
`endif

  // Next dividend bit enters the row below the running partial remainder
  assign w_x9   = {r_r, r_d[3'd7 - r_k]};
  assign w_mask = approx_mask(r_k, r_m, APPROX_START, APPROX_MAX);

  div_row u_row (
    .x9   (w_x9),
    .y    (r_y),
    .mask (w_mask),
    .qs   (w_qs),
    .rout (w_rout)
  );

  assign quotient  = r_quot;
  assign remainder = r_rem;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and status outputs decoded from the state
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_dz_accept ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_k == K_LAST) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (w_accept) w_next = w_dz_accept ? DONE : RUN;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-iteration row update and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_y    <= '0;
      r_m    <= 1'b0;
      r_q    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_r <= dividend[15:8];
      r_d <= dividend[7:0];
      r_y <= divisor;
      r_m <= approx_mode;
      r_k <= '0;
      r_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz <= w_dz_accept;
      if (w_dz_accept) begin
        r_quot <= 8'hFF;
        r_rem  <= 8'h00;
      end
`endif
    end else if (r_state == RUN) begin
      // Quotient bits arrive MSB first, so shift them in from the bottom.
      r_q <= {r_q[6:0], w_qs};
      r_r <= w_rout;
      r_k <= r_k + 3'd1;
      if (r_k == K_LAST) begin
        r_quot <= {r_q[6:0], w_qs};
        r_rem  <= w_rout;
      end
    end
  end

endmodule
